ascii_bcd_converter: RTL and testbench

Registered bidirectional converter between packed ASCII decimal strings and packed BCD. Channel A2B turns DIGITS ASCII characters into DIGITS BCD nibbles and raises a validity flag. Channel B2A turns DIGITS BCD nibbles into ASCII characters. It sits between the text/UART front end and the numeric datapath; the two channels are independent and run concurrently.

---
 rtl/ascii_bcd_pkg.sv | 17 +
 rtl/ascii_bcd_digit.sv | 19 +
 rtl/ascii_bcd_converter.sv | 69 ++++++
 tb/tb_ascii_bcd_converter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ascii_bcd_pkg.sv
// Shared constants and digit-classification helpers for the ASCII <-> BCD converter.
package ascii_bcd_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_ERR  = 8'h3F;

    // Bit 7 set always falls outside 0x30..0x39, so no separate test is needed.
    function automatic logic is_ascii_digit(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

    function automatic logic is_bcd_digit(input logic [3:0] n);
        return n <= 4'd9;
    endfunction

endpackage

// File: rtl/ascii_bcd_digit.sv
// One character/nibble slice: ASCII char -> BCD nibble and BCD nibble -> ASCII char.
module ascii_bcd_digit
    import ascii_bcd_pkg::*;
(
    input  logic [7:0] ascii_char,
    input  logic [3:0] nibble,
    output logic [3:0] digit,
    output logic       ascii_err,
    output logic [7:0] char_out,
    output logic       bcd_err
);

    assign ascii_err = !is_ascii_digit(ascii_char);
    assign digit     = ascii_err ? 4'd0 : ascii_char[3:0];

    assign bcd_err   = !is_bcd_digit(nibble);
    assign char_out  = bcd_err ? ASCII_ERR : (ASCII_ZERO + {4'd0, nibble});

endmodule

// File: rtl/ascii_bcd_converter.sv
// Registered bidirectional ASCII <-> packed BCD converter; two independent 1-cycle channels.
module ascii_bcd_converter
    import ascii_bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a2b_valid_in,
    input  logic [8*DIGITS-1:0]   ascii_in,
    output logic                  a2b_valid_out,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  check,
    output logic [DIGITS-1:0]     a2b_err_mask,
    input  logic                  b2a_valid_in,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  b2a_valid_out,
    output logic [8*DIGITS-1:0]   ascii_out,
    output logic                  b2a_err
);

    logic [4*DIGITS-1:0] a2b_digits;
    logic [DIGITS-1:0]   a2b_errs;
    logic [8*DIGITS-1:0] b2a_chars;
    logic [DIGITS-1:0]   b2a_errs;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        ascii_bcd_digit u_digit (
            .ascii_char (ascii_in[8*g +: 8]),
            .nibble     (bcd_in[4*g +: 4]),
            .digit      (a2b_digits[4*g +: 4]),
            .ascii_err  (a2b_errs[g]),
            .char_out   (b2a_chars[8*g +: 8]),
            .bcd_err    (b2a_errs[g])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a2b_valid_out <= 1'b0;
            bcd_out       <= '0;
            check         <= 1'b0;
            a2b_err_mask  <= '0;
        end else begin
            a2b_valid_out <= a2b_valid_in;
            if (a2b_valid_in) begin
                bcd_out      <= a2b_digits;
                a2b_err_mask <= a2b_errs;
                check        <= ~|a2b_errs;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b2a_valid_out <= 1'b0;
            ascii_out     <= '0;
            b2a_err       <= 1'b0;
        end else begin
            b2a_valid_out <= b2a_valid_in;
            if (b2a_valid_in) begin
                ascii_out <= b2a_chars;
                b2a_err   <= |b2a_errs;
            end
        end
    end

endmodule

// File: tb/tb_ascii_bcd_converter.sv
// Self-checking bench: vector table driven into both channels, scoreboard queues checked by a monitor.
module tb_ascii_bcd_converter;

    localparam int DIGITS = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  a2b_valid_in;
    logic [8*DIGITS-1:0]   ascii_in;
    logic                  a2b_valid_out;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  check;
    logic [DIGITS-1:0]     a2b_err_mask;
    logic                  b2a_valid_in;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  b2a_valid_out;
    logic [8*DIGITS-1:0]   ascii_out;
    logic                  b2a_err;

    ascii_bcd_converter #(.DIGITS(DIGITS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .a2b_valid_in  (a2b_valid_in),
        .ascii_in      (ascii_in),
        .a2b_valid_out (a2b_valid_out),
        .bcd_out       (bcd_out),
        .check         (check),
        .a2b_err_mask  (a2b_err_mask),
        .b2a_valid_in  (b2a_valid_in),
        .bcd_in        (bcd_in),
        .b2a_valid_out (b2a_valid_out),
        .ascii_out     (ascii_out),
        .b2a_err       (b2a_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a_v;
        logic [31:0] ascii;
        logic [15:0] exp_bcd;
        logic        exp_chk;
        logic [3:0]  exp_mask;
        logic        b_v;
        logic [15:0] bcd;
        logic [31:0] exp_ascii;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic        chk;
        logic [3:0]  mask;
    } a2b_item_t;

    typedef struct {
        logic [31:0] ascii;
        logic        err;
    } b2a_item_t;

    vec_t      vecs[11];
    a2b_item_t a_q[$];
    b2a_item_t b_q[$];
    a2b_item_t a_last;
    b2a_item_t b_last;
    int        total  = 0;
    int        passed = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " a2b_valid_out"}, 64'(a2b_valid_out), 64'd0);
        check_eq({tag, " bcd_out"},       64'(bcd_out),       64'd0);
        check_eq({tag, " check"},         64'(check),         64'd0);
        check_eq({tag, " a2b_err_mask"},  64'(a2b_err_mask),  64'd0);
        check_eq({tag, " b2a_valid_out"}, 64'(b2a_valid_out), 64'd0);
        check_eq({tag, " ascii_out"},     64'(ascii_out),     64'd0);
        check_eq({tag, " b2a_err"},       64'(b2a_err),       64'd0);
    endtask

    // Drive one cycle of stimulus at the falling edge and log expectations.
    task automatic drive(input vec_t v);
        @(negedge clk);
        a2b_valid_in = v.a_v;
        ascii_in     = v.a_v ? v.ascii : $urandom;
        b2a_valid_in = v.b_v;
        bcd_in       = v.b_v ? v.bcd : 16'($urandom);
        if (v.a_v) a_q.push_back('{bcd: v.exp_bcd, chk: v.exp_chk, mask: v.exp_mask});
        if (v.b_v) b_q.push_back('{ascii: v.exp_ascii, err: v.exp_err});
    endtask

    // Monitor: a queued item must appear exactly one edge later; otherwise outputs hold.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (a_q.size() > 0) begin
                a_last = a_q.pop_front();
                check_eq("a2b_valid_out", 64'(a2b_valid_out), 64'd1);
            end else begin
                check_eq("a2b_valid_out idle", 64'(a2b_valid_out), 64'd0);
            end
            check_eq("bcd_out",      64'(bcd_out),      64'(a_last.bcd));
            check_eq("check",        64'(check),        64'(a_last.chk));
            check_eq("a2b_err_mask", 64'(a2b_err_mask), 64'(a_last.mask));
            if (b_q.size() > 0) begin
                b_last = b_q.pop_front();
                check_eq("b2a_valid_out", 64'(b2a_valid_out), 64'd1);
            end else begin
                check_eq("b2a_valid_out idle", 64'(b2a_valid_out), 64'd0);
            end
            check_eq("ascii_out", 64'(ascii_out), 64'(b_last.ascii));
            check_eq("b2a_err",   64'(b2a_err),   64'(b_last.err));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //           a_v ascii         bcd      chk  mask  b_v bcd      ascii         err
        vecs[0]  = '{1, 32'h31393837, 16'h1987, 1, 4'h0, 1, 16'h1987, 32'h31393837, 0};
        vecs[1]  = '{1, 32'h39393939, 16'h9999, 1, 4'h0, 1, 16'h9999, 32'h39393939, 0};
        vecs[2]  = '{1, 32'h36353430, 16'h6540, 1, 4'h0, 0, 16'h0000, 32'h0,        0};
        vecs[3]  = '{0, 32'h0,        16'h0,    0, 4'h0, 1, 16'h0000, 32'h30303030, 0};
        vecs[4]  = '{1, 32'h313A2F37, 16'h1007, 0, 4'h6, 1, 16'hFFFF, 32'h3F3F3F3F, 1};
        vecs[5]  = '{1, 32'h30303030, 16'h0000, 1, 4'h0, 1, 16'h1A0F, 32'h313F303F, 1};
        vecs[6]  = '{0, 32'h0,        16'h0,    0, 4'h0, 0, 16'h0,    32'h0,        0};
        vecs[7]  = '{1, 32'hB9308041, 16'h0000, 0, 4'hB, 1, 16'h9A09, 32'h393F3039, 1};
        vecs[8]  = '{1, 32'h00000000, 16'h0000, 0, 4'hF, 0, 16'h0,    32'h0,        0};
        vecs[9]  = '{0, 32'h0,        16'h0,    0, 4'h0, 1, 16'h0909, 32'h30393039, 0};
        vecs[10] = '{1, 32'h2F303A39, 16'h0009, 0, 4'hA, 1, 16'h0A90, 32'h303F3930, 1};

        a_last       = '{bcd: '0, chk: 1'b0, mask: '0};
        b_last       = '{ascii: '0, err: 1'b0};
        rst_n        = 1'b0;
        a2b_valid_in = 1'b0;
        b2a_valid_in = 1'b0;
        ascii_in     = '0;
        bcd_in       = '0;
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset release: outputs stay 0 (monitor checks against zero a_last/b_last).
        repeat (2) drive('{0, 32'h0, 16'h0, 0, 4'h0, 0, 16'h0, 32'h0, 0});

        foreach (vecs[i]) drive(vecs[i]);
        drive('{0, 32'h0, 16'h0, 0, 4'h0, 0, 16'h0, 32'h0, 0});

        // Asynchronous reset while both channels show valid data.
        drive('{1, 32'h31323334, 16'h1234, 1, 4'h0, 1, 16'h5678, 32'h35363738, 0});
        @(posedge clk);
        #3;
        check_eq("pre-reset a2b_valid_out", 64'(a2b_valid_out), 64'd1);
        check_eq("pre-reset b2a_valid_out", 64'(b2a_valid_out), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        a_q.delete();
        b_q.delete();
        a_last = '{bcd: '0, chk: 1'b0, mask: '0};
        b_last = '{ascii: '0, err: 1'b0};

        // Word presented while reset is held must be discarded.
        @(negedge clk);
        a2b_valid_in = 1'b1;
        ascii_in     = 32'h39393939;
        b2a_valid_in = 1'b1;
        bcd_in       = 16'h9999;
        @(posedge clk);
        #2;
        check_all_zero("reset held");
        @(negedge clk);
        a2b_valid_in = 1'b0;
        b2a_valid_in = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        #2;
        check_all_zero("post-reset idle");
        repeat (2) drive('{0, 32'h0, 16'h0, 0, 4'h0, 0, 16'h0, 32'h0, 0});

        // Traffic resumes normally after reset.
        drive('{1, 32'h34323130, 16'h4210, 1, 4'h0, 1, 16'h0042, 32'h30303432, 0});
        drive('{0, 32'h0, 16'h0, 0, 4'h0, 0, 16'h0, 32'h0, 0});
        @(posedge clk);
        #3;
        check_eq("a2b queue drained", 64'(a_q.size()), 64'd0);
        check_eq("b2a queue drained", 64'(b_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
